// File: rtl/uart_alu_interface_if.sv
// rtl/uart_alu_interface_if.sv - FIFO, ALU and status signal bundle for uart_alu_interface
//
// Purpose: groups the RX FIFO, TX FIFO, ALU and status signals of the
// UART-to-ALU host controller so they travel as one port.
// Signals:
//   rx_empty, r_data, rd_uart : RX FIFO (first-word-fall-through) side
//   tx_full, w_data, wr_uart  : TX FIFO side
//   alu_a, alu_b, alu_op      : operand/opcode registers driven to the ALU
//   alu_result                : combinational ALU result
//   busy, frame_err           : controller status
// Modports:
//   master : the controller (drives strobes, operands, status)
//   slave  : the environment (FIFOs, ALU, observers)
interface uart_alu_interface_if #(
  parameter int DBIT  = 8,
  parameter int NB_OP = 6
);
  logic             rx_empty;
  logic [DBIT-1:0]  r_data;
  logic             rd_uart;
  logic             tx_full;
  logic [DBIT-1:0]  w_data;
  logic             wr_uart;
  logic [DBIT-1:0]  alu_a;
  logic [DBIT-1:0]  alu_b;
  logic [NB_OP-1:0] alu_op;
  logic [DBIT-1:0]  alu_result;
  logic             busy;
  logic             frame_err;

  modport master (
    input  rx_empty, r_data, tx_full, alu_result,
    output rd_uart, w_data, wr_uart, alu_a, alu_b, alu_op, busy, frame_err
  );

  modport slave (
    output rx_empty, r_data, tx_full, alu_result,
    input  rd_uart, w_data, wr_uart, alu_a, alu_b, alu_op, busy, frame_err
  );
endinterface

// File: rtl/uart_alu_interface.sv
// rtl/uart_alu_interface.sv - UART host controller: 3-byte command frames to ALU, 1-byte response
//
// Purpose: pops opcode, operand A and operand B from the RX FIFO, holds them
// on the external combinational ALU, latches the result and pushes it into
// the TX FIFO. A frame stalled between bytes for TIMEOUT_CYC cycles is
// dropped and flagged with a one-cycle frame_err pulse.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : uart_alu_interface_if.master (FIFO handshakes, ALU operands,
//           ALU result, busy, frame_err)
module uart_alu_interface #(
  parameter int DBIT        = 8,
  parameter int NB_OP       = 6,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int TO_BITS     = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_alu_interface_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GET_A = 3'd1,
    GET_B = 3'd2,
    EXEC  = 3'd3,
    SEND  = 3'd4
  } state_t;

  localparam logic [TO_BITS-1:0] CNT_LAST = TO_BITS'(TIMEOUT_CYC - 1);

  state_t             state_q, state_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic [DBIT-1:0]    a_q, a_d;
  logic [DBIT-1:0]    b_q, b_d;
  logic [DBIT-1:0]    res_q, res_d;
  logic [TO_BITS-1:0] cnt_q, cnt_d;
  logic               ferr_q, ferr_d;

  logic rx_state;
  logic accept;
  logic expired;

  // A byte is taken whenever a receive state sees a non-empty FIFO; this is
  // also the pop strobe, so capture and pop share one edge.
  assign rx_state = (state_q == IDLE) || (state_q == GET_A) || (state_q == GET_B);
  assign accept   = rx_state && !bus.rx_empty;
  // Expiry loses to an arriving byte in the same cycle.
  assign expired  = ((state_q == GET_A) || (state_q == GET_B)) && !accept && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = '0;
    ferr_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d    = bus.r_data[NB_OP-1:0];
          state_d = GET_A;
        end
      end
      GET_A: begin
        if (accept) begin
          a_d     = bus.r_data;
          state_d = GET_B;
        end else if (expired) begin
          state_d = IDLE;
          ferr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GET_B: begin
        if (accept) begin
          b_d     = bus.r_data;
          state_d = EXEC;
        end else if (expired) begin
          state_d = IDLE;
          ferr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      EXEC: begin
        // Operands have been stable on the ALU since the GET_B edge.
        res_d   = bus.alu_result;
        state_d = SEND;
      end
      SEND: begin
        if (!bus.tx_full) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.rd_uart   = accept;
  assign bus.wr_uart   = (state_q == SEND) && !bus.tx_full;
  assign bus.w_data    = res_q;
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.alu_op    = op_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.frame_err = ferr_q;

endmodule

// File: tb/tb_uart_alu_interface.sv
// tb/tb_uart_alu_interface.sv - scoreboard bench for uart_alu_interface
module tb_uart_alu_interface;

  localparam int DBIT  = 8;
  localparam int NB_OP = 6;
  localparam int TO    = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_alu_interface_if #(.DBIT(DBIT), .NB_OP(NB_OP)) bus ();

  uart_alu_interface #(
    .DBIT(DBIT), .NB_OP(NB_OP), .TIMEOUT_CYC(TO), .TO_BITS(5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // External ALU stub.
  always_comb begin
    case (bus.alu_op)
      6'h20:   bus.alu_result = bus.alu_a + bus.alu_b;
      6'h22:   bus.alu_result = bus.alu_a - bus.alu_b;
      6'h24:   bus.alu_result = bus.alu_a & bus.alu_b;
      6'h25:   bus.alu_result = bus.alu_a | bus.alu_b;
      6'h26:   bus.alu_result = bus.alu_a ^ bus.alu_b;
      6'h27:   bus.alu_result = ~(bus.alu_a | bus.alu_b);
      6'h02:   bus.alu_result = bus.alu_a >> bus.alu_b[2:0];
      default: bus.alu_result = bus.alu_a;
    endcase
  end

  // Reference model in plain integer arithmetic.
  function automatic int model(int op, int a, int b);
    int r;
    case (op % 64)
      32:      r = a + b;
      34:      r = a - b;
      36:      r = a & b;
      37:      r = a | b;
      38:      r = a ^ b;
      39:      r = ~(a | b);
      2:       r = a / (1 << (b % 8));
      default: r = a;
    endcase
    return r & 255;
  endfunction

  typedef struct {
    int op;
    int a;
    int b;
    int res;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] rx_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int n_tx     = 0;
  int n_ferr   = 0;
  int cyc      = 0;
  int last_acc_edge = 0;
  int last_ferr_cyc = 0;
  logic pend = 1'b0;
  logic stop_tog = 1'b0;

  function automatic void chk(string name, int act, int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endfunction

  function automatic void refresh();
    bus.rx_empty = (rx_q.size() == 0);
    bus.r_data   = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // RX FIFO model: a pop seen mid-cycle takes effect just after the edge.
  always @(posedge clk) begin
    #1;
    if (pend) begin
      if (rx_q.size() == 0) begin
        chk("pop_from_empty", 1, 0);
      end else begin
        void'(rx_q.pop_front());
      end
      refresh();
    end
  end

  // Monitor: scoreboard pop and compare on every TX push.
  always @(negedge clk) begin
    pend = bus.rd_uart && reset;
    if (reset && bus.rd_uart) last_acc_edge = cyc + 1;
    if (reset && bus.wr_uart) begin
      n_tx++;
      if (exp_q.size() == 0) begin
        chk("unexpected_tx", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("w_data", int'(bus.w_data), e.res);
        chk("alu_op", int'(bus.alu_op), e.op);
        chk("alu_a",  int'(bus.alu_a),  e.a);
        chk("alu_b",  int'(bus.alu_b),  e.b);
      end
    end
    if (bus.frame_err) begin
      n_ferr++;
      last_ferr_cyc = cyc;
    end
  end

  task automatic push(input logic [7:0] b);
    rx_q.push_back(b);
    refresh();
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic expect_frame(input int op, input int a, input int b);
    exp_t e;
    e.op  = op % 64;
    e.a   = a;
    e.b   = b;
    e.res = model(op, a, b);
    exp_q.push_back(e);
  endtask

  task automatic send_frame(input int op, input int a, input int b, input int max_gap);
    expect_frame(op, a, b);
    push(8'(op));
    if (max_gap > 0) wait_cycles($urandom_range(0, max_gap));
    push(8'(a));
    if (max_gap > 0) wait_cycles($urandom_range(0, max_gap));
    push(8'(b));
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || rx_q.size() != 0 || bus.busy) && t < 3000) begin
      wait_cycles(1);
      t++;
    end
    if (t >= 3000) chk("drain_timeout", 1, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_ferr;
    int base_tx;
    int ops[8];
    ops = '{32'h20, 32'h22, 32'h24, 32'h25, 32'h26, 32'h27, 32'h02, 32'h3f};

    reset = 1'b1;
    bus.tx_full = 1'b0;
    refresh();
    #1 reset = 1'b0;
    wait_cycles(3);

    chk("rst_busy",      int'(bus.busy), 0);
    chk("rst_rd_uart",   int'(bus.rd_uart), 0);
    chk("rst_wr_uart",   int'(bus.wr_uart), 0);
    chk("rst_w_data",    int'(bus.w_data), 0);
    chk("rst_alu_a",     int'(bus.alu_a), 0);
    chk("rst_alu_b",     int'(bus.alu_b), 0);
    chk("rst_alu_op",    int'(bus.alu_op), 0);
    chk("rst_frame_err", int'(bus.frame_err), 0);
    reset = 1'b1;
    wait_cycles(1);

    // Basic add.
    send_frame(32'h20, 32'h05, 32'h03, 0);
    drain();
    chk("add_busy_idle", int'(bus.busy), 0);
    chk("add_tx_count", n_tx, 1);

    // Opcode masking and 8-bit wrap.
    send_frame(32'hE0, 32'hFF, 32'h02, 0);
    drain();
    chk("mask_tx_count", n_tx, 2);

    // TX backpressure.
    base_tx = n_tx;
    base_ferr = n_ferr;
    bus.tx_full = 1'b1;
    send_frame(32'h22, 32'h10, 32'h03, 0);
    wait_cycles(8);
    wait_cycles(50);
    chk("bp_busy", int'(bus.busy), 1);
    chk("bp_wr_uart", int'(bus.wr_uart), 0);
    chk("bp_no_tx", n_tx - base_tx, 0);
    chk("bp_no_ferr", n_ferr - base_ferr, 0);
    bus.tx_full = 1'b0;
    #1;
    chk("bp_wr_same_cycle", int'(bus.wr_uart), 1);
    drain();
    chk("bp_tx_once", n_tx - base_tx, 1);

    // Inter-byte timeout after opcode and A.
    base_tx = n_tx;
    base_ferr = n_ferr;
    push(8'h20);
    push(8'h07);
    wait_cycles(40);
    chk("to_ferr_count", n_ferr - base_ferr, 1);
    chk("to_ferr_delay", last_ferr_cyc - last_acc_edge, TO);
    chk("to_busy", int'(bus.busy), 0);
    chk("to_no_tx", n_tx - base_tx, 0);
    send_frame(32'h20, 32'h01, 32'h01, 0);
    drain();

    // B arrives in the expiry cycle: byte wins.
    base_ferr = n_ferr;
    expect_frame(32'h20, 32'h09, 32'h04);
    push(8'h20);
    push(8'h09);
    repeat (17) @(posedge clk);
    #2;
    push(8'h04);
    drain();
    chk("race_no_ferr", n_ferr - base_ferr, 0);

    // Asynchronous reset mid-frame.
    push(8'h20);
    push(8'h55);
    wait_cycles(4);
    #1 reset = 1'b0;
    #1;
    chk("arst_busy",  int'(bus.busy), 0);
    chk("arst_alu_a", int'(bus.alu_a), 0);
    chk("arst_alu_op", int'(bus.alu_op), 0);
    wait_cycles(2);
    rx_q.delete();
    refresh();
    reset = 1'b1;
    wait_cycles(1);
    send_frame(32'h20, 32'h10, 32'h20, 0);
    drain();

    // Randomised frames with byte gaps and TX backpressure.
    fork
      begin
        while (!stop_tog) begin
          @(posedge clk);
          #2;
          bus.tx_full = ($urandom_range(0, 3) == 0);
        end
        bus.tx_full = 1'b0;
      end
    join_none
    for (int i = 0; i < 25; i++) begin
      send_frame(ops[$urandom_range(0, 7)] | ($urandom_range(0, 3) << 6),
                 $urandom_range(0, 255), $urandom_range(0, 255), 4);
    end
    drain();
    stop_tog = 1'b1;
    wait_cycles(2);

    chk("total_ferr", n_ferr, 1);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
